// File: rtl/drum_pkg.sv
// Shared types and constants for the drum grid, its column/grid logic and the audio sink.
package drum_pkg;

    localparam int unsigned AMP_W   = 18;
    localparam int unsigned FRAC_W  = 17;
    localparam int unsigned AUDIO_W = 32;

    // Audio core register byte offsets from the core base address
    localparam logic [31:0] REG_FIFOSPACE = 32'h0000_0004;
    localparam logic [31:0] REG_LEFTDATA  = 32'h0000_0008;
    localparam logic [31:0] REG_RIGHTDATA = 32'h0000_000C;

    // Signed 1.17 fixed-point node amplitude
    typedef logic signed [AMP_W-1:0] fix_1_17_t;

    typedef logic [AUDIO_W-1:0] audio_t;

    // Upper half of the fifospace register: free words in the left/right write FIFOs
    typedef struct packed {
        logic [7:0] wslc;
        logic [7:0] wsrc;
    } fifospace_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_STEP = 3'd1,
        ST_RD_SPACE  = 3'd2,
        ST_CHK_SPACE = 3'd3,
        ST_WR_LEFT   = 3'd4,
        ST_WR_RIGHT  = 3'd5
    } sink_state_e;

    // True when both write FIFOs have at least min_space free words
    function automatic logic space_ok(input fifospace_t s, input int unsigned min_space);
        return (32'(s.wslc) >= min_space) && (32'(s.wsrc) >= min_space);
    endfunction

endpackage

// File: rtl/audio_sample_scale.sv
// Saturating conversion of a signed 1.17 amplitude to a 32-bit signed audio sample.
// Purely combinational; the amplitude is shifted left by GAIN_SHIFT (0..20).
module audio_sample_scale
    import drum_pkg::*;
#(
    parameter int unsigned GAIN_SHIFT = 14
) (
    input  fix_1_17_t amp,
    output audio_t    sample_c
);

    localparam int unsigned EXT_W = AUDIO_W + GAIN_SHIFT;

    logic signed [EXT_W-1:0]     shifted;
    logic [EXT_W-AUDIO_W:0]      top_bits;
    logic                        overflow;

    // Sign-extend, shift, and clamp anything outside the 32-bit signed range
    always_comb begin
        shifted  = EXT_W'(amp) <<< GAIN_SHIFT;
        top_bits = shifted[EXT_W-1:AUDIO_W-1];
        overflow = (top_bits != '0) && (top_bits != '1);
        sample_c = shifted[AUDIO_W-1:0];
        if (overflow) begin
            sample_c = shifted[EXT_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

endmodule

// File: rtl/drum_audio_sink.sv
// Audio sink for the drum grid: captures the centre-node amplitude once per time step,
// pushes it to the codec left/right FIFOs over Avalon-MM and requests the next step.
// Optional build macro AUDIO_UNDERRUN_CNT_EN adds the underrun_cnt output.
module drum_audio_sink
    import drum_pkg::*;
#(
    parameter logic [31:0] AUDIO_BASE = 32'h0000_0000,
    parameter int unsigned GAIN_SHIFT = 14,
    parameter int unsigned MIN_SPACE  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [AMP_W-1:0]   center_node_amp,
    input  logic               step_done,
    output logic               step_req,
    output logic [31:0]        avm_address,
    output logic               avm_read,
    output logic               avm_write,
    output logic [31:0]        avm_writedata,
    input  logic [31:0]        avm_readdata,
    input  logic               avm_waitrequest,
    output logic [AUDIO_W-1:0] sample_out
`ifdef AUDIO_UNDERRUN_CNT_EN
    ,
    output logic [15:0]        underrun_cnt
`endif
);

    sink_state_e state_q, state_d;
    audio_t      sample_q, sample_d;
    audio_t      scaled_c;
    fifospace_t  space_q, space_d;
    audio_t      sample_out_d;
    logic        step_req_d;
    logic        read_d;
    logic        write_d;
    logic [31:0] address_d;
    logic [31:0] writedata_d;
    logic        unused_readdata_c;

    // Only the FIFO free-space counts in the upper half of fifospace are used
    assign unused_readdata_c = ^avm_readdata[15:0];

    // Amplitude to audio sample conversion, registered when a step completes
    audio_sample_scale #(
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_scale (
        .amp      (center_node_amp),
        .sample_c (scaled_c)
    );

    // Next-state logic; bus outputs are decoded from the next state so they are registered
    always_comb begin
        state_d      = state_q;
        sample_d     = sample_q;
        space_d      = space_q;
        sample_out_d = sample_out;
        step_req_d   = 1'b0;
        read_d       = 1'b0;
        write_d      = 1'b0;
        address_d    = '0;
        writedata_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    step_req_d = 1'b1;
                    state_d    = ST_WAIT_STEP;
                end
            end
            ST_WAIT_STEP: begin
                if (step_done) begin
                    sample_d = scaled_c;
                    state_d  = ST_RD_SPACE;
                end
            end
            ST_RD_SPACE: begin
                if (!avm_waitrequest) begin
                    space_d = avm_readdata[31:16];
                    state_d = ST_CHK_SPACE;
                end
            end
            ST_CHK_SPACE: begin
                state_d = space_ok(space_q, MIN_SPACE) ? ST_WR_LEFT : ST_RD_SPACE;
            end
            ST_WR_LEFT: begin
                if (!avm_waitrequest) begin
                    state_d = ST_WR_RIGHT;
                end
            end
            ST_WR_RIGHT: begin
                if (!avm_waitrequest) begin
                    sample_out_d = sample_q;
                    if (enable) begin
                        step_req_d = 1'b1;
                        state_d    = ST_WAIT_STEP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_RD_SPACE: begin
                read_d    = 1'b1;
                address_d = AUDIO_BASE + REG_FIFOSPACE;
            end
            ST_WR_LEFT: begin
                write_d     = 1'b1;
                address_d   = AUDIO_BASE + REG_LEFTDATA;
                writedata_d = sample_d;
            end
            ST_WR_RIGHT: begin
                write_d     = 1'b1;
                address_d   = AUDIO_BASE + REG_RIGHTDATA;
                writedata_d = sample_d;
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset abandons any bus cycle in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            sample_q      <= '0;
            space_q       <= '0;
            step_req      <= 1'b0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            sample_out    <= '0;
        end else begin
            state_q       <= state_d;
            sample_q      <= sample_d;
            space_q       <= space_d;
            step_req      <= step_req_d;
            avm_address   <= address_d;
            avm_read      <= read_d;
            avm_write     <= write_d;
            avm_writedata <= writedata_d;
            sample_out    <= sample_out_d;
        end
    end

`ifdef AUDIO_UNDERRUN_CNT_EN
    // Count space polls that found a FIFO too full, saturating at all ones
    always_ff @(posedge clk) begin
        if (!reset) begin
            underrun_cnt <= '0;
        end else if ((state_q == ST_CHK_SPACE) && !space_ok(space_q, MIN_SPACE)
                     && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_drum_audio_sink.sv
// Scoreboard bench for drum_audio_sink: stimulus pushes expected codec writes,
// a negedge monitor pops and compares each accepted write and watches bus holds.
`timescale 1ns/1ps
module tb_drum_audio_sink;
    import drum_pkg::*;

    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam logic [31:0] A_LEFT  = BASE + 32'h8;
    localparam logic [31:0] A_RIGHT = BASE + 32'hC;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [17:0] center_node_amp = '0;
    logic        step_done = 1'b0;
    logic        step_req;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] sample_out;
`ifdef AUDIO_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    fix_1_17_t   sat_amp = '0;
    audio_t      sat_out;

    int          total = 0;
    int          bad = 0;
    int          n_wr = 0;
    int          n_req = 0;
    int          rd_idx = 0;
    int          low_start = 0;
    int          low_len = 0;
    logic [31:0] space_after = 32'hFFFF_0000;
    wr_t         exp_q[$];

    logic [31:0] p_addr = '0;
    logic [31:0] p_data = '0;
    logic        p_rd = 1'b0;
    logic        p_wr = 1'b0;
    logic        p_stall = 1'b0;

    logic [17:0] sat_in  [6] = '{18'h1_FFFF, 18'h2_0000, 18'h0_7FFF, 18'h0_8000, 18'h3_8000, 18'h3_7FFF};
    logic [31:0] sat_exp [6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};

    always #5 clk = ~clk;

    drum_audio_sink #(
        .AUDIO_BASE (BASE),
        .GAIN_SHIFT (14),
        .MIN_SPACE  (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .center_node_amp (center_node_amp),
        .step_done       (step_done),
        .step_req        (step_req),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .sample_out      (sample_out)
`ifdef AUDIO_UNDERRUN_CNT_EN
        ,
        .underrun_cnt    (underrun_cnt)
`endif
    );

    audio_sample_scale #(
        .GAIN_SHIFT (16)
    ) u_sat (
        .amp      (sat_amp),
        .sample_c (sat_out)
    );

    // Codec fifospace model: low_len polls with WSRC=0, then space_after
    assign avm_readdata = ((rd_idx - low_start) < low_len) ? 32'hFF00_0000 : space_after;

    always @(posedge clk) begin
        if (reset && avm_read && !avm_waitrequest) rd_idx <= rd_idx + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = step_req;
        end
        chk({name, "_step_req"}, 32'(seen), 32'd1);
    endtask

    // One grid step: pulse step_done, expect left then right write of exp_s
    task automatic run_sample(input string name, input logic [17:0] amp, input logic [31:0] exp_s,
                              input int stall, input bit drop_en, input int exp_reads);
        int lat;
        int r0;
        int q0;
        r0 = rd_idx;
        tick();
        step_done = 1'b1;
        center_node_amp = amp;
        exp_q.push_back(wr_t'({A_LEFT, exp_s}));
        exp_q.push_back(wr_t'({A_RIGHT, exp_s}));
        tick();
        step_done = 1'b0;
        lat = 1;
        while (!avm_write && lat < 200) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 32'(avm_write && lat >= 3), 32'd1);
        chk({name, "_reads"}, 32'(rd_idx - r0), 32'(exp_reads));
        if (stall > 0) begin
            avm_waitrequest = 1'b1;
            step_done = 1'b1;
            center_node_amp = 18'h2_AAAA;
            tick();
            step_done = 1'b0;
            repeat (stall - 1) tick();
            avm_waitrequest = 1'b0;
        end
        if (drop_en) begin
            enable = 1'b0;
            q0 = n_req;
            repeat (20) tick();
            chk({name, "_no_req"}, 32'(n_req - q0), 32'd0);
            chk({name, "_idle"}, 32'(dut.state_q), 32'(ST_IDLE));
        end else begin
            wait_req(name);
        end
        chk({name, "_sample_out"}, sample_out, exp_s);
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: scoreboard compare of accepted writes, hold and exclusivity checks
    always @(negedge clk) begin
        wr_t e;
        if (reset) begin
            chk("rw_excl", 32'(avm_read & avm_write), 32'd0);
            if (p_stall) begin
                chk("hold_addr", avm_address, p_addr);
                chk("hold_data", avm_writedata, p_data);
                chk("hold_ctl", {30'd0, avm_read, avm_write}, {30'd0, p_rd, p_wr});
            end
            if (avm_write && !avm_waitrequest) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    chk("extra_write", avm_address, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", avm_address, e.addr);
                    chk("wr_data", avm_writedata, e.data);
                end
            end
            if (step_req) n_req++;
            p_stall = (avm_read || avm_write) && avm_waitrequest;
            p_addr  = avm_address;
            p_data  = avm_writedata;
            p_rd    = avm_read;
            p_wr    = avm_write;
        end else begin
            p_stall = 1'b0;
        end
    end

    initial begin
        int w0;
        logic [31:0] so;

        // Saturating scaler at GAIN_SHIFT=16
        for (int i = 0; i < 6; i++) begin
            sat_amp = sat_in[i];
            #1;
            chk($sformatf("sat_%0d", i), sat_out, sat_exp[i]);
        end

        // Reset state
        repeat (3) tick();
        chk("rst_step_req", 32'(step_req), 32'd0);
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);
        chk("rst_sample", sample_out, 32'd0);
`ifdef AUDIO_UNDERRUN_CNT_EN
        chk("rst_underrun", 32'(underrun_cnt), 32'd0);
`endif

        reset = 1'b1;
        enable = 1'b1;
        wait_req("start");

        run_sample("half",   18'h1_0000, 32'h4000_0000, 0, 1'b0, 1);
        run_sample("neghalf", 18'h3_0000, 32'hC000_0000, 0, 1'b0, 1);
        run_sample("maxpos", 18'h1_FFFF, 32'h7FFF_C000, 0, 1'b0, 1);
        run_sample("maxneg", 18'h2_0000, 32'h8000_0000, 0, 1'b0, 1);
        run_sample("lsb",    18'h0_0001, 32'h0000_4000, 0, 1'b0, 1);

        // Five polls with no right-FIFO space, then space appears
        low_start = rd_idx;
        low_len = 5;
        space_after = 32'h8080_0000;
        run_sample("underrun", 18'h0_8000, 32'h2000_0000, 0, 1'b0, 6);
        low_len = 0;
        space_after = 32'hFFFF_0000;
`ifdef AUDIO_UNDERRUN_CNT_EN
        chk("underrun_cnt", 32'(underrun_cnt), 32'd5);
`endif

        run_sample("stall", 18'h3_FFFF, 32'hFFFF_C000, 4, 1'b0, 1);
        run_sample("drop",  18'h0_4000, 32'h1000_0000, 0, 1'b1, 1);

        // step_done while parked must not capture or write
        w0 = n_wr;
        so = sample_out;
        step_done = 1'b1;
        center_node_amp = 18'h1_5555;
        tick();
        step_done = 1'b0;
        repeat (5) tick();
        chk("idle_ignore_wr", 32'(n_wr - w0), 32'd0);
        chk("idle_ignore_so", sample_out, so);

        enable = 1'b1;
        wait_req("reenable");

        // Reset while a fifospace read is stalled
        w0 = n_wr;
        tick();
        step_done = 1'b1;
        center_node_amp = 18'h1_0000;
        tick();
        step_done = 1'b0;
        chk("rdspace_read", 32'(avm_read), 32'd1);
        avm_waitrequest = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_read", 32'(avm_read), 32'd0);
        chk("mid_rst_write", 32'(avm_write), 32'd0);
        chk("mid_rst_addr", avm_address, 32'd0);
        chk("mid_rst_req", 32'(step_req), 32'd0);
        chk("mid_rst_sample", sample_out, 32'd0);
        avm_waitrequest = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        wait_req("fresh");
        chk("mid_rst_no_wr", 32'(n_wr - w0), 32'd0);
        run_sample("after_rst", 18'h1_0000, 32'h4000_0000, 0, 1'b0, 1);

        repeat (3) tick();
        chk("req_total", 32'(n_req), 32'd11);
        chk("wr_total", 32'(n_wr), 32'd18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
